hsv_conv_arbiter: RTL

- Round-robin arbiter and sequencer that shares one multi-cycle RGB->HSV converter among NREQ pixel requesters, e.g. per-facelet sampling units of the cube-colour pipeline.
- Grants one request at a time and latches its RGB.
- Pulses the converter enable, waits for its done flag, and returns the HSV result tagged with the requester ID over a valid/ready response port.

---
 rtl/hsv_conv_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/hsv_conv_arbiter.sv
// hsv_conv_arbiter: round-robin front end that shares one multi-cycle
// RGB->HSV converter among NREQ pixel requesters.
// Flow: grant one request and latch its RGB, pulse the converter enable,
// wait for its done flag, then return the HSV result tagged with the
// requester index over a valid/ready response port.
// Optional build macro HSV_CONV_ARB_TIMEOUT_EN adds a conversion watchdog
// and the timeout_err output. The watchdog expires after TIMEOUT cycles
// in WAIT and then returns an all-zero result.
module hsv_conv_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*24-1:0]   req_rgb,
    output logic [NREQ-1:0]      ack,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [23:0]          rsp_hsv,
    output logic                 conv_enable,
    output logic [23:0]          conv_rgb,
    input  logic [23:0]          conv_hsv,
    input  logic                 conv_done,
    output logic                 busy
`ifdef HSV_CONV_ARB_TIMEOUT_EN
    ,
    output logic                 timeout_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state_q;
    logic [IDW-1:0]       last_q;
    logic [IDW-1:0]       id_q;
    logic [NREQ-1:0]      ack_q;
    logic                 rsp_valid_q;
    logic [IDW-1:0]       rsp_id_q;
    logic [23:0]          rsp_hsv_q;
    logic                 conv_enable_q;
    logic [23:0]          conv_rgb_q;

    // Next grant, derived combinationally from the round-robin pointer.
    logic                 grant_vld_d;
    logic [IDW-1:0]       grant_idx_d;
    logic [NREQ-1:0]      grant_oh_d;
    logic [23:0]          grant_rgb_d;

`ifdef HSV_CONV_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 6) ? $clog2(TIMEOUT + 1) : 6;
    logic [CNT_W-1:0]     wd_cnt_q;
    logic                 timeout_err_q;
`endif

    // Round-robin search: scan last+1, last+2, ... modulo NREQ and take the
    // first requester whose req bit is set.
    always_comb begin
        grant_vld_d = 1'b0;
        grant_idx_d = '0;
        grant_oh_d  = '0;
        grant_rgb_d = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            int unsigned idx;
            logic [NREQ-1:0] sel;
            idx = (32'(last_q) + k) % NREQ;
            sel = NREQ'(1) << idx;
            if (!grant_vld_d && ((req & sel) != '0)) begin
                grant_vld_d = 1'b1;
                grant_idx_d = IDW'(idx);
                grant_oh_d  = sel;
                grant_rgb_d = req_rgb[24*idx +: 24];
            end
        end
    end

    // Sequencer FSM; all outputs are registered here.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            last_q        <= IDW'(NREQ - 1);
            id_q          <= '0;
            ack_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_hsv_q     <= '0;
            conv_enable_q <= 1'b0;
            conv_rgb_q    <= '0;
`ifdef HSV_CONV_ARB_TIMEOUT_EN
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            // Single-cycle pulses default low every cycle.
            ack_q         <= '0;
            conv_enable_q <= 1'b0;
`ifdef HSV_CONV_ARB_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
            unique case (state_q)
                S_IDLE: begin
                    if (grant_vld_d) begin
                        ack_q      <= grant_oh_d;
                        conv_rgb_q <= grant_rgb_d;
                        id_q       <= grant_idx_d;
                        last_q     <= grant_idx_d;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // A done level still high belongs to the previous
                    // conversion; start only once it has cleared.
                    if (!conv_done) begin
                        conv_enable_q <= 1'b1;
                        state_q       <= S_WAIT;
`ifdef HSV_CONV_ARB_TIMEOUT_EN
                        wd_cnt_q      <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (conv_done) begin
                        rsp_hsv_q   <= conv_hsv;
                        rsp_id_q    <= id_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
`ifdef HSV_CONV_ARB_TIMEOUT_EN
                    // The counter holds the number of completed WAIT cycles,
                    // so it fires on the TIMEOUT-th WAIT cycle.
                    else if (wd_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        rsp_hsv_q     <= 24'h000000;
                        rsp_id_q      <= id_q;
                        rsp_valid_q   <= 1'b1;
                        timeout_err_q <= 1'b1;
                        state_q       <= S_RESP;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack         = ack_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_hsv     = rsp_hsv_q;
    assign conv_enable = conv_enable_q;
    assign conv_rgb    = conv_rgb_q;
    assign busy        = (state_q != S_IDLE);
`ifdef HSV_CONV_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`endif

endmodule
